// File: rtl/memwb_skid_reg_pkg.sv
// Shared pipeline definitions: default widths, skid-buffer occupancy encoding
// and the writeback bundle layout used by the stage registers.
package memwb_skid_reg_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int RAW_DEF   = 5;
    localparam int CNT_W_DEF = 32;

    localparam logic [RAW_DEF-1:0] ZERO_REG = '0;

    // Bit 0 = head valid, bit 1 = skid valid; the skid is only ever valid behind a valid head.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    typedef struct packed {
        logic                reg_write;
        logic                mem_to_reg;
        logic [RAW_DEF-1:0]  write_reg;
        logic [XLEN_DEF-1:0] alu_out;
        logic [XLEN_DEF-1:0] read_data;
    } wb_bundle_t;

endpackage

// File: rtl/memwb_skid_reg_skid_buf.sv
// Generic 2-entry valid/ready skid buffer over a packed bundle, with a
// synchronous flush. in_ready is registered (no path from out_ready).
module pipe_skid_buf
    import memwb_skid_reg_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic [1:0]   r_state;
    logic [W-1:0] r_head;
    logic [W-1:0] r_skid;
    logic         w_in_fire;
    logic         w_out_fire;

    assign o_valid    = r_state[0];
    assign o_ready    = ~r_state[1];
    assign o_data     = r_head;
    assign w_in_fire  = i_valid & o_ready;
    assign w_out_fire = o_valid & i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
        end else if (i_flush) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_head  <= i_data;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_head <= i_data;
                    end else if (w_in_fire) begin
                        r_skid  <= i_data;
                        r_state <= ST_FULL;
                    end else if (w_out_fire) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        r_head  <= r_skid;
                        r_state <= ST_ONE;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/memwb_skid_reg.sv
// MEM/WB stage register: skid-buffered writeback bundle with x0 write
// suppression, a forwarding tap for the hazard unit and a retire counter.
module memwb_skid_reg
    import memwb_skid_reg_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RAW   = RAW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             RegWriteM,
    input  logic             MemtoRegM,
    input  logic [RAW-1:0]   WriteRegM,
    input  logic [XLEN-1:0]  ALUOutM,
    input  logic [XLEN-1:0]  ReadDataM,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             RegWriteW,
    output logic             MemtoRegW,
    output logic [RAW-1:0]   WriteRegW,
    output logic [XLEN-1:0]  ALUOutW,
    output logic [XLEN-1:0]  ReadDataW,
    output logic             fwd_valid,
    output logic [RAW-1:0]   fwd_reg,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef struct packed {
        logic            reg_write;
        logic            mem_to_reg;
        logic [RAW-1:0]  write_reg;
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] read_data;
    } wb_t;

    wb_t              w_in_bundle;
    wb_t              w_head;
    logic             w_head_valid;
    logic             w_out_fire;
    logic [CNT_W-1:0] r_retire_cnt;

    // Writes to x0 are dropped at capture so nothing downstream sees them.
    assign w_in_bundle.reg_write  = RegWriteM & (WriteRegM != '0);
    assign w_in_bundle.mem_to_reg = MemtoRegM;
    assign w_in_bundle.write_reg  = WriteRegM;
    assign w_in_bundle.alu_out    = ALUOutM;
    assign w_in_bundle.read_data  = ReadDataM;

    pipe_skid_buf #(
        .W($bits(wb_t))
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_in_bundle),
        .o_valid (w_head_valid),
        .i_ready (out_ready),
        .o_data  (w_head)
    );

    assign out_valid  = w_head_valid;
    assign RegWriteW  = w_head_valid & w_head.reg_write;
    assign MemtoRegW  = w_head.mem_to_reg;
    assign WriteRegW  = w_head.write_reg;
    assign ALUOutW    = w_head.alu_out;
    assign ReadDataW  = w_head.read_data;

    assign fwd_valid  = w_head_valid & RegWriteW;
    assign fwd_reg    = w_head.write_reg;
    assign fwd_data   = w_head.mem_to_reg ? w_head.read_data : w_head.alu_out;

    assign w_out_fire = w_head_valid & out_ready;
    assign retire_cnt = r_retire_cnt;

    // Flush does not clear the count: a bundle consumed during a flush still retired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retire_cnt <= '0;
        end else if (w_out_fire && RegWriteW && (r_retire_cnt != {CNT_W{1'b1}})) begin
            r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_memwb_skid_reg.sv
// Bench for memwb_skid_reg: directed vector table, async-reset and saturation
// sequences, then random traffic against a queue-based FIFO model.
module tb_memwb_skid_reg;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, RegWriteM, MemtoRegM;
    logic [4:0]  WriteRegM;
    logic [31:0] ALUOutM, ReadDataM;

    logic        in_ready, out_valid, RegWriteW, MemtoRegW, fwd_valid;
    logic [4:0]  WriteRegW, fwd_reg;
    logic [31:0] ALUOutW, ReadDataW, fwd_data, retire_cnt;

    logic        b_in_ready, b_out_valid, b_RegWriteW, b_MemtoRegW, b_fwd_valid;
    logic [4:0]  b_WriteRegW, b_fwd_reg;
    logic [31:0] b_ALUOutW, b_ReadDataW, b_fwd_data;
    logic [3:0]  b_retire_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    memwb_skid_reg #(.XLEN(32), .RAW(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM),
        .ALUOutM(ALUOutM), .ReadDataM(ReadDataM), .out_valid(out_valid), .out_ready(out_ready),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .WriteRegW(WriteRegW),
        .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg),
        .fwd_data(fwd_data), .retire_cnt(retire_cnt)
    );

    memwb_skid_reg #(.XLEN(32), .RAW(5), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM),
        .ALUOutM(ALUOutM), .ReadDataM(ReadDataM), .out_valid(b_out_valid), .out_ready(out_ready),
        .RegWriteW(b_RegWriteW), .MemtoRegW(b_MemtoRegW), .WriteRegW(b_WriteRegW),
        .ALUOutW(b_ALUOutW), .ReadDataW(b_ReadDataW), .fwd_valid(b_fwd_valid), .fwd_reg(b_fwd_reg),
        .fwd_data(b_fwd_data), .retire_cnt(b_retire_cnt)
    );

    typedef struct {
        logic        iv, orr, fl, rw, mtr;
        logic [4:0]  wr;
        logic [31:0] alu, rd;
        logic        e_ov, e_ir, e_rw, e_fv;
        logic [31:0] e_alu, e_fwd;
        int          e_cnt;
    } vec_t;

    typedef struct {
        logic        rw, mtr;
        logic [4:0]  wr;
        logic [31:0] alu, rd;
    } mb_t;

    vec_t tv[17];
    mb_t  q[$];
    int   mcnt, mcnt4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic orr, input logic fl, input logic rw,
                         input logic mtr, input logic [4:0] wr, input logic [31:0] alu,
                         input logic [31:0] rd);
        in_valid = iv; out_ready = orr; flush = fl; RegWriteM = rw;
        MemtoRegM = mtr; WriteRegM = wr; ALUOutM = alu; ReadDataM = rd;
    endtask

    function automatic vec_t mk(input logic iv, input logic orr, input logic fl, input logic rw,
                                input logic mtr, input logic [4:0] wr, input logic [31:0] alu,
                                input logic [31:0] rd, input logic e_ov, input logic e_ir,
                                input logic e_rw, input logic e_fv, input logic [31:0] e_alu,
                                input logic [31:0] e_fwd, input int e_cnt);
        vec_t v;
        v.iv = iv; v.orr = orr; v.fl = fl; v.rw = rw; v.mtr = mtr; v.wr = wr;
        v.alu = alu; v.rd = rd; v.e_ov = e_ov; v.e_ir = e_ir; v.e_rw = e_rw;
        v.e_fv = e_fv; v.e_alu = e_alu; v.e_fwd = e_fwd; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, ".RegWriteW"}, {31'd0, RegWriteW}, 32'd0);
        chk({tag, ".MemtoRegW"}, {31'd0, MemtoRegW}, 32'd0);
        chk({tag, ".WriteRegW"}, {27'd0, WriteRegW}, 32'd0);
        chk({tag, ".ALUOutW"}, ALUOutW, 32'd0);
        chk({tag, ".ReadDataW"}, ReadDataW, 32'd0);
        chk({tag, ".fwd_valid"}, {31'd0, fwd_valid}, 32'd0);
        chk({tag, ".fwd_reg"}, {27'd0, fwd_reg}, 32'd0);
        chk({tag, ".fwd_data"}, fwd_data, 32'd0);
        chk({tag, ".retire_cnt"}, retire_cnt, 32'd0);
        chk({tag, ".retire_cnt4"}, {28'd0, b_retire_cnt}, 32'd0);
    endtask

    task automatic chk_model();
        mb_t h;
        chk("rnd.out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk("rnd.in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        if (q.size() > 0) begin
            h = q[0];
            chk("rnd.RegWriteW", {31'd0, RegWriteW}, {31'd0, h.rw});
            chk("rnd.MemtoRegW", {31'd0, MemtoRegW}, {31'd0, h.mtr});
            chk("rnd.WriteRegW", {27'd0, WriteRegW}, {27'd0, h.wr});
            chk("rnd.ALUOutW", ALUOutW, h.alu);
            chk("rnd.ReadDataW", ReadDataW, h.rd);
            chk("rnd.fwd_valid", {31'd0, fwd_valid}, {31'd0, h.rw});
            chk("rnd.fwd_reg", {27'd0, fwd_reg}, {27'd0, h.wr});
            chk("rnd.fwd_data", fwd_data, h.mtr ? h.rd : h.alu);
        end else begin
            chk("rnd.RegWriteW_idle", {31'd0, RegWriteW}, 32'd0);
            chk("rnd.fwd_valid_idle", {31'd0, fwd_valid}, 32'd0);
        end
        chk("rnd.retire_cnt", retire_cnt, mcnt);
        chk("rnd.retire_cnt4", {28'd0, b_retire_cnt}, mcnt4);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        rst = 1'b1;
        #3;
        chk_zero("reset");
        @(posedge clk); #2;
        rst = 1'b0;

        //             iv orr fl rw mtr wr  alu        rd            ov ir rw fv e_alu      e_fwd         cnt
        tv[0]  = mk(1, 1, 0, 1, 0, 5'd3, 32'd1,    32'd0,        1, 1, 1, 1, 32'd1,    32'd1,        0);
        tv[1]  = mk(1, 1, 0, 1, 0, 5'd3, 32'd2,    32'd0,        1, 1, 1, 1, 32'd2,    32'd2,        1);
        tv[2]  = mk(1, 1, 0, 1, 0, 5'd3, 32'd3,    32'd0,        1, 1, 1, 1, 32'd3,    32'd3,        2);
        tv[3]  = mk(1, 1, 0, 1, 0, 5'd3, 32'd4,    32'd0,        1, 1, 1, 1, 32'd4,    32'd4,        3);
        tv[4]  = mk(0, 1, 0, 0, 0, 5'd0, 32'd0,    32'd0,        0, 1, 0, 0, 32'd0,    32'd0,        4);
        tv[5]  = mk(1, 0, 0, 1, 0, 5'd3, 32'd5,    32'd0,        1, 1, 1, 1, 32'd5,    32'd5,        4);
        tv[6]  = mk(1, 0, 0, 1, 0, 5'd3, 32'd6,    32'd0,        1, 0, 1, 1, 32'd5,    32'd5,        4);
        tv[7]  = mk(1, 0, 0, 1, 0, 5'd3, 32'd7,    32'd0,        1, 0, 1, 1, 32'd5,    32'd5,        4);
        tv[8]  = mk(0, 1, 0, 0, 0, 5'd0, 32'd0,    32'd0,        1, 1, 1, 1, 32'd6,    32'd6,        5);
        tv[9]  = mk(0, 1, 0, 0, 0, 5'd0, 32'd0,    32'd0,        0, 1, 0, 0, 32'd0,    32'd0,        6);
        tv[10] = mk(1, 0, 0, 1, 0, 5'd0, 32'd8,    32'd0,        1, 1, 0, 0, 32'd8,    32'd8,        6);
        tv[11] = mk(0, 1, 0, 0, 0, 5'd0, 32'd0,    32'd0,        0, 1, 0, 0, 32'd0,    32'd0,        6);
        tv[12] = mk(1, 0, 0, 1, 1, 5'd5, 32'h10,   32'hDEADBEEF, 1, 1, 1, 1, 32'h10,   32'hDEADBEEF, 6);
        tv[13] = mk(1, 1, 0, 1, 0, 5'd5, 32'h10,   32'hDEADBEEF, 1, 1, 1, 1, 32'h10,   32'h10,       7);
        tv[14] = mk(1, 0, 0, 1, 0, 5'd5, 32'h20,   32'h0,        1, 0, 1, 1, 32'h10,   32'h10,       7);
        tv[15] = mk(1, 0, 1, 1, 0, 5'd5, 32'h30,   32'h0,        0, 1, 0, 0, 32'h0,    32'h0,        7);
        tv[16] = mk(0, 1, 0, 0, 0, 5'd0, 32'h0,    32'h0,        0, 1, 0, 0, 32'h0,    32'h0,        7);

        for (int i = 0; i < 17; i++) begin
            drive(tv[i].iv, tv[i].orr, tv[i].fl, tv[i].rw, tv[i].mtr, tv[i].wr, tv[i].alu, tv[i].rd);
            @(posedge clk); #2;
            chk($sformatf("vec%0d.out_valid", i), {31'd0, out_valid}, {31'd0, tv[i].e_ov});
            chk($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, {31'd0, tv[i].e_ir});
            chk($sformatf("vec%0d.RegWriteW", i), {31'd0, RegWriteW}, {31'd0, tv[i].e_rw});
            chk($sformatf("vec%0d.fwd_valid", i), {31'd0, fwd_valid}, {31'd0, tv[i].e_fv});
            chk($sformatf("vec%0d.retire_cnt", i), retire_cnt, tv[i].e_cnt);
            chk($sformatf("vec%0d.retire_cnt4", i), {28'd0, b_retire_cnt}, tv[i].e_cnt);
            if (tv[i].e_ov) begin
                chk($sformatf("vec%0d.ALUOutW", i), ALUOutW, tv[i].e_alu);
                chk($sformatf("vec%0d.fwd_data", i), fwd_data, tv[i].e_fwd);
            end
        end

        // Asynchronous reset asserted between edges with a bundle held
        drive(1, 0, 0, 1, 1, 5'd7, 32'hAB, 32'h55);
        @(posedge clk); #2;
        drive(0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        chk("async.pre_out_valid", {31'd0, out_valid}, 32'd1);
        chk("async.pre_fwd_data", fwd_data, 32'h55);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async");
        @(posedge clk); #2;
        rst = 1'b0;

        // Twenty writebacks: full-width counter reaches 20, 4-bit one sticks at 15
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 0, 1, 0, 5'd1, i, 32'd0);
            @(posedge clk); #2;
        end
        drive(0, 1, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("sat.retire_cnt", retire_cnt, 32'd20);
        chk("sat.retire_cnt4", {28'd0, b_retire_cnt}, 32'd15);
        chk("sat.out_valid", {31'd0, out_valid}, 32'd0);

        // Random traffic against the FIFO model
        rst = 1'b1;
        #1;
        rst = 1'b0;
        q.delete();
        mcnt = 0;
        mcnt4 = 0;
        for (int c = 0; c < 400; c++) begin
            logic iv, orr, fl, rw, mtr, m_in_fire, m_out_fire;
            logic [4:0] wr;
            logic [31:0] alu, rd;
            mb_t b;
            chk_model();
            iv  = ($urandom_range(0, 9) < 7);
            orr = ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 19) == 0);
            rw  = ($urandom_range(0, 3) != 0);
            mtr = $urandom_range(0, 1);
            wr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            alu = $urandom;
            rd  = $urandom;
            drive(iv, orr, fl, rw, mtr, wr, alu, rd);
            m_in_fire  = iv && (q.size() < 2);
            m_out_fire = orr && (q.size() > 0);
            b.rw = rw && (wr != 5'd0);
            b.mtr = mtr; b.wr = wr; b.alu = alu; b.rd = rd;
            @(posedge clk); #2;
            if (m_out_fire && q[0].rw) begin
                mcnt++;
                if (mcnt4 < 15) mcnt4++;
            end
            if (fl) begin
                q.delete();
            end else begin
                if (m_out_fire) void'(q.pop_front());
                if (m_in_fire) q.push_back(b);
            end
        end
        chk_model();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/memwb_skid_reg.md
# memwb_skid_reg

Parametrised MEM/WB stage register for the 5-stage pipeline. It carries the writeback bundle from memory stage to writeback stage under a valid/ready handshake, with a 2-entry skid buffer so back-pressure from writeback never drops data. It adds synchronous flush, x0 write suppression, a forwarding tap for the hazard unit, and a saturating retired-writeback counter. Sits between the data-memory read path and the register-file write port.

## Interface
Parameters:
- XLEN, 32, data width of ALU result and memory read data
- RAW, 5, register-address width
- CNT_W, 32, width of retired-writeback counter

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; discards all held entries
- in_valid  in  1  MEM bundle valid
- in_ready  out  1  stage can accept a bundle
- RegWriteM  in  1  register write enable
- MemtoRegM  in  1  select memory data for writeback
- WriteRegM  in  RAW  destination register
- ALUOutM  in  XLEN  ALU result
- ReadDataM  in  XLEN  memory read data
- out_valid  out  1  WB bundle valid
- out_ready  in  1  writeback accepts the bundle
- RegWriteW, MemtoRegW, WriteRegW, ALUOutW, ReadDataW  out  1/1/RAW/XLEN/XLEN  registered WB bundle (head entry)
- fwd_valid  out  1  out_valid & RegWriteW
- fwd_reg  out  RAW  equals WriteRegW
- fwd_data  out  XLEN  MemtoRegW ? ReadDataW : ALUOutW
- retire_cnt  out  CNT_W  count of accepted writebacks with RegWriteW=1

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Two entries: head (drives W outputs) and skid. States by valid bits: EMPTY, ONE (head only), FULL (head+skid).
- in_ready = !skid_valid (registered, no combinational path from out_ready).
- out_valid = head_valid.
- Capture: RegWrite stored as RegWriteM & (WriteRegM != 0); the other fields are stored verbatim.
- Transitions (flush=0):
  - EMPTY: in_fire -> ONE, head <= input.
  - ONE: in_fire & out_fire -> ONE, head <= input; in_fire & !out_fire -> FULL, skid <= input; !in_fire & out_fire -> EMPTY; else hold.
  - FULL: no in_fire possible; out_fire -> ONE, head <= skid; else hold.
- flush=1: next state EMPTY regardless of in_fire/out_fire; a bundle presented that cycle is dropped. An out_fire in the same cycle still counts (it was consumed).
- Data fields of invalid entries are don't-care, but RegWriteW is forced 0 whenever head_valid=0.
- retire_cnt increments by 1 on out_fire & RegWriteW; saturates at all-ones; cleared only by rst.
- Order is strictly FIFO; no entry is duplicated or lost except by flush.

## Timing
- rst asserted: immediately, head_valid=skid_valid=0, in_ready=1, out_valid=0, all W fields 0, fwd_valid=0, fwd_reg=0, fwd_data=0, retire_cnt=0.
- Latency: bundle accepted at edge N is visible on W outputs after edge N when the stage was EMPTY or draining (ONE with out_fire).
- Throughput: 1 bundle/cycle with out_ready held high.
- Back-pressure: one extra bundle absorbed after out_ready falls; in_ready drops the following cycle.
- fwd_* are combinational from head registers only; valid in the same cycle as out_valid.
- rst mid-operation: all entries discarded asynchronously; no counter change.

## Structure
- Shared pipeline package: XLEN/RAW defaults, zero-register constant, writeback bundle struct (reg_write, mem_to_reg, write_reg, alu_out, read_data) reused by other stage registers.
- One sub-module natural: pipe_skid_buf, generic 2-entry valid/ready skid buffer over a packed bundle with flush; memwb_skid_reg adds x0 suppression, forwarding tap and counter.

## Test plan
- Reset then stream 4 bundles (ALUOutM=1..4, RegWriteM=1, WriteRegM=3) with out_ready=1 -> W outputs show 1..4 on consecutive cycles, one cycle after each input; retire_cnt=4.
- Stream with out_ready=0 for 3 cycles -> exactly 2 bundles held, in_ready=0 from the 3rd cycle; release -> both emerge in order, none lost.
- RegWriteM=1, WriteRegM=0 -> RegWriteW=0, fwd_valid=0, retire_cnt unchanged.
- FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, RegWriteW=0; flushed bundles never appear.
- MemtoRegM=1, ReadDataM=0xDEADBEEF, ALUOutM=0x10 -> fwd_data=0xDEADBEEF; with MemtoRegM=0 -> 0x10.
- Assert rst asynchronously mid-stream (between edges) -> outputs zero immediately; CNT_W=4 run of 20 writebacks -> retire_cnt saturates at 15.
